// File: rtl/mipi_dphy_pkg.sv
// Shared MIPI D-PHY transmit definitions: HS lane state encoding, sync byte,
// and the counter widths used by the lane serializer.
package mipi_dphy_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PAIR_W  = 2;
  localparam int unsigned TRAIL_W = 4;

  // HS sync sequence, sent LSB first ahead of the payload.
  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hB8;

  // Pair index of the last bit pair in a byte; also the byte-accept slot.
  localparam logic [PAIR_W-1:0] LAST_PAIR = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DATA  = 2'd2,
    TRAIL = 2'd3
  } hs_state_e;

endpackage

// File: rtl/hs_lane_serializer.sv
// HS lane serializer: turns a byte stream into bit pairs for a DDR output
// stage. Sends the sync byte, streams payload bytes back-to-back, then holds
// the inverted last bit for TRAIL_CYCLES cycles before returning to idle.
//
// Ports:
//   TX_DDR_clk   DDR transmit clock (single clock of the block)
//   TX_rst_n     asynchronous active-low reset
//   TxRequestHS  HS transmission request
//   TxByteHS     payload byte, LSB first
//   TxValidHS    TxByteHS is valid
//   TxReadyHS    byte accept strobe (transfer on valid & ready at rising edge)
//   Serial_B1    even-index bit for the rising-edge DDR register
//   Serial_B2    odd-index bit for the falling-edge DDR register
//   Enable       downstream driver enable
//   Busy         high whenever not idle
module hs_lane_serializer
  import mipi_dphy_pkg::*;
#(
  parameter int unsigned TRAIL_CYCLES = 4
) (
  input  logic              TX_DDR_clk,
  input  logic              TX_rst_n,
  input  logic              TxRequestHS,
  input  logic [BYTE_W-1:0] TxByteHS,
  input  logic              TxValidHS,
  output logic              TxReadyHS,
  output logic              Serial_B1,
  output logic              Serial_B2,
  output logic              Enable,
  output logic              Busy
);

  hs_state_e           state_q, state_d;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic [TRAIL_W-1:0]  trail_q, trail_d;
  logic                ready_d, b1_d, b2_d, en_d, busy_d;
  logic                transfer_c;

  // State, counters and all outputs registered together.
  always_ff @(posedge TX_DDR_clk or negedge TX_rst_n) begin
    if (!TX_rst_n) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      shreg_q   <= '0;
      trail_q   <= '0;
      TxReadyHS <= 1'b0;
      Serial_B1 <= 1'b0;
      Serial_B2 <= 1'b0;
      Enable    <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      shreg_q   <= shreg_d;
      trail_q   <= trail_d;
      TxReadyHS <= ready_d;
      Serial_B1 <= b1_d;
      Serial_B2 <= b2_d;
      Enable    <= en_d;
      Busy      <= busy_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    shreg_d    = shreg_q;
    trail_d    = trail_q;
    b1_d       = 1'b0;
    b2_d       = 1'b0;
    transfer_c = TxValidHS && TxReadyHS;

    unique case (state_q)
      IDLE: begin
        if (TxRequestHS) begin
          state_d = SYNC;
          pair_d  = '0;
          b1_d    = SYNC_BYTE[0];
          b2_d    = SYNC_BYTE[1];
          shreg_d = SYNC_BYTE >> 2;
        end
      end

      SYNC, DATA: begin
        if (pair_q == LAST_PAIR) begin
          if (transfer_c) begin
            // Load the next byte so its first pair follows with no gap.
            state_d = DATA;
            pair_d  = '0;
            b1_d    = TxByteHS[0];
            b2_d    = TxByteHS[1];
            shreg_d = TxByteHS >> 2;
          end else begin
            // Trail level is the inverse of the final transmitted bit.
            state_d = TRAIL;
            trail_d = TRAIL_W'(TRAIL_CYCLES - 1);
            b1_d    = ~Serial_B2;
            b2_d    = ~Serial_B2;
          end
        end else begin
          pair_d  = pair_q + PAIR_W'(1);
          b1_d    = shreg_q[0];
          b2_d    = shreg_q[1];
          shreg_d = shreg_q >> 2;
        end
      end

      TRAIL: begin
        // Request is ignored here; idle is always visited before a new sync.
        if (trail_q == '0) begin
          state_d = IDLE;
        end else begin
          trail_d = trail_q - TRAIL_W'(1);
          b1_d    = Serial_B1;
          b2_d    = Serial_B2;
        end
      end

      default: state_d = IDLE;
    endcase

    en_d    = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
    // Ready covers the last pair of a byte only; it never looks at valid.
    ready_d = ((state_d == SYNC) || (state_d == DATA)) &&
              (pair_d == LAST_PAIR) && TxRequestHS;
  end

endmodule

// File: tb/tb_hs_lane_serializer.sv
// Directed bench for hs_lane_serializer with a per-cycle expected-output queue.
module tb_hs_lane_serializer;

  localparam int unsigned TRAIL = 4;

  logic       TX_DDR_clk;
  logic       TX_rst_n;
  logic       TxRequestHS;
  logic [7:0] TxByteHS;
  logic       TxValidHS;
  logic       TxReadyHS;
  logic       Serial_B1;
  logic       Serial_B2;
  logic       Enable;
  logic       Busy;

  // {b1, b2, enable, ready, busy}
  typedef struct packed {
    logic b1;
    logic b2;
    logic en;
    logic rdy;
    logic busy;
  } obs_t;

  obs_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  string tag   = "init";

  hs_lane_serializer #(.TRAIL_CYCLES(TRAIL)) dut (
    .TX_DDR_clk  (TX_DDR_clk),
    .TX_rst_n    (TX_rst_n),
    .TxRequestHS (TxRequestHS),
    .TxByteHS    (TxByteHS),
    .TxValidHS   (TxValidHS),
    .TxReadyHS   (TxReadyHS),
    .Serial_B1   (Serial_B1),
    .Serial_B2   (Serial_B2),
    .Enable      (Enable),
    .Busy        (Busy)
  );

  initial TX_DDR_clk = 1'b0;
  always #5 TX_DDR_clk = ~TX_DDR_clk;

  function automatic obs_t sample();
    obs_t o;
    o = {Serial_B1, Serial_B2, Enable, TxReadyHS, Busy};
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed b1,b2,en,rdy,busy=%b required=%b", name, got, want);
    end
  endtask

  // Drive inputs for the next rising edge, queue the outputs that edge must
  // produce, then pop and compare on the falling edge.
  task automatic drive(input logic req, input logic valid, input logic [7:0] b,
                       input obs_t e);
    obs_t want;
    TxRequestHS = req;
    TxValidHS   = valid;
    TxByteHS    = b;
    exp_q.push_back(e);
    @(negedge TX_DDR_clk);
    want = exp_q.pop_front();
    check(tag, sample(), want);
  endtask

  // Four pairs of byte b. The first cycle's inputs start the byte (from idle
  // or as a transfer); rq[k-1] is the request driven for pair k's edge.
  task automatic beats(input logic [7:0] b, input logic ld_valid,
                       input logic [7:0] ld_byte, input logic [2:0] rq);
    logic [7:0] bv;
    bv = b;
    drive(1'b1, ld_valid, ld_byte, {bv[0], bv[1], 1'b1, 1'b0, 1'b1});
    for (int k = 1; k < 4; k++) begin
      drive(rq[k-1], 1'b0, 8'h00,
            {bv[2*k], bv[2*k+1], 1'b1, (k == 3) ? rq[2] : 1'b0, 1'b1});
    end
  endtask

  // TRAIL cycles at level v followed by one idle cycle.
  task automatic trail(input logic v, input logic req);
    repeat (TRAIL) drive(req, 1'b0, 8'h00, {v, v, 1'b1, 1'b0, 1'b1});
    drive(req, 1'b0, 8'h00, 5'b00000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    TX_rst_n    = 1'b0;
    TxRequestHS = 1'b0;
    TxValidHS   = 1'b0;
    TxByteHS    = 8'h00;
    #1;
    tag = "reset";
    check(tag, sample(), 5'b00000);
    @(negedge TX_DDR_clk);
    @(negedge TX_DDR_clk);
    TX_rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 5'b00000);

    // Single byte A5 then trail
    tag = "single_a5";
    beats(8'hB8, 1'b0, 8'h00, 3'b111);
    beats(8'hA5, 1'b1, 8'hA5, 3'b000);
    trail(1'b0, 1'b0);

    // Back-to-back 01, 80
    tag = "b2b_01_80";
    beats(8'hB8, 1'b0, 8'h00, 3'b111);
    beats(8'h01, 1'b1, 8'h01, 3'b111);
    beats(8'h80, 1'b1, 8'h80, 3'b000);
    trail(1'b0, 1'b0);

    // No valid at first ready slot: straight to trail
    tag = "no_valid";
    beats(8'hB8, 1'b0, 8'h00, 3'b111);
    trail(1'b0, 1'b0);

    // Request drops mid-byte FF: byte completes, no ready
    tag = "req_drop_ff";
    beats(8'hB8, 1'b0, 8'h00, 3'b111);
    beats(8'hFF, 1'b1, 8'hFF, 3'b001);
    trail(1'b0, 1'b0);

    // Request held through trail (byte 3C ends in 0, trail level 1)
    tag = "req_hold";
    beats(8'hB8, 1'b0, 8'h00, 3'b111);
    beats(8'h3C, 1'b1, 8'h3C, 3'b000);
    trail(1'b1, 1'b1);
    tag = "req_hold_resync";
    beats(8'hB8, 1'b0, 8'h00, 3'b111);

    // Reset asserted mid-DATA, then restart with sync
    tag = "rst_mid_data";
    drive(1'b1, 1'b1, 8'h5A, 5'b01101);
    drive(1'b1, 1'b0, 8'h00, 5'b01101);
    #2;
    TX_rst_n = 1'b0;
    #1;
    tag = "rst_async";
    check(tag, sample(), 5'b00000);
    @(negedge TX_DDR_clk);
    @(negedge TX_DDR_clk);
    tag = "rst_held";
    check(tag, sample(), 5'b00000);
    TX_rst_n = 1'b1;
    tag = "rst_resync";
    beats(8'hB8, 1'b0, 8'h00, 3'b000);
    trail(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hs_lane_serializer.md
HS_LANE_SERIALIZER -- requirements
Module: hs_lane_serializer

Interface
REQ-001 SHALL have parameter: TRAIL_CYCLES, 4, number of TX_DDR_clk cycles in the HS trail (legal range 1..15).
REQ-002 SHALL have port: TX_DDR_clk  input  1  DDR transmit clock, the single clock of the block.
REQ-003 SHALL have port: TX_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: TxRequestHS  input  1  HS transmission request from the protocol layer.
REQ-005 SHALL have port: TxByteHS  input  8  payload byte, LSB transmitted first.
REQ-006 SHALL have port: TxValidHS  input  1  TxByteHS holds a valid byte.
REQ-007 SHALL have port: TxReadyHS  output  1  byte accept strobe; a transfer occurs when TxValidHS and TxReadyHS are both high on a TX_DDR_clk rising edge.
REQ-008 SHALL have port: Serial_B1  output  1  bit for the downstream rising-edge DDR register (even bit index).
REQ-009 SHALL have port: Serial_B2  output  1  bit for the downstream falling-edge DDR register (odd bit index).
REQ-010 SHALL have port: Enable  output  1  downstream driver enable.
REQ-011 SHALL have port: Busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SYNC, DATA, TRAIL; all state and outputs registered on TX_DDR_clk rising edge.
REQ-013 SHALL move IDLE->SYNC on the first edge sampling TxRequestHS=1; the first sync pair SHALL appear on Serial_B1/B2 in the following cycle.
REQ-014 SHALL, in SYNC, emit sync byte 8'hB8 as four pairs LSB first: (0,0),(0,1),(1,1),(0,1).
REQ-015 SHALL emit each byte in exactly 4 cycles; pair k carries Serial_B1=bit[2k], Serial_B2=bit[2k+1], with pair index 0..3 kept by a 2-bit counter that wraps 3->0.
REQ-016 SHALL drive TxReadyHS=1 only in SYNC or DATA, during pair index 3, while TxRequestHS=1; otherwise 0.
REQ-017 SHALL, on a transfer at pair index 3, load TxByteHS and enter or stay in DATA, so bytes stream back-to-back with no gap.
REQ-018 SHALL, at pair index 3 with no transfer (TxValidHS=0 or TxRequestHS=0), enter TRAIL next cycle.
REQ-019 SHALL complete the current byte when TxRequestHS falls mid-byte; no truncation.
REQ-020 SHALL, in TRAIL, drive Serial_B1=Serial_B2=inverse of the last transmitted Serial_B2 for exactly TRAIL_CYCLES cycles, then enter IDLE.
REQ-021 SHALL ignore TxRequestHS during TRAIL; a request held high through TRAIL re-enters SYNC from IDLE on the next edge.
REQ-022 SHALL drive Enable=1 in SYNC, DATA, TRAIL and Enable=0, Serial_B1=Serial_B2=0 in IDLE.
REQ-023 SHALL not change TxReadyHS timing based on TxValidHS (ready is independent of valid).

Reset
REQ-024 SHALL, while TX_rst_n=0, force state IDLE, pair counter 0, shift register 0, trail counter 0, TxReadyHS=0, Serial_B1=0, Serial_B2=0, Enable=0, Busy=0.
REQ-025 SHALL, on reset assertion mid-transmission, abort immediately with no trail; first request after release starts with SYNC.

Structure
REQ-026 SHALL take state encoding typedef and SYNC_BYTE constant (8'hB8) from shared package mipi_dphy_pkg.
REQ-027 SHALL be a single module with no sub-modules; outputs connect directly to the DDR output flip-flop stage inputs Serial_B1, Serial_B2, Enable.

Verification
REQ-028 SHALL test reset: assert TX_rst_n=0 mid-DATA -> all outputs 0 asynchronously, state IDLE; after release with TxRequestHS=1 -> sync pairs (0,0),(0,1),(1,1),(0,1).
REQ-029 SHALL test single byte 8'hA5, TRAIL_CYCLES=4 -> after sync, pairs (1,0),(1,0),(0,1),(0,1), then four cycles of (0,0) with Enable=1, then Enable=0.
REQ-030 SHALL test back-to-back 8'h01, 8'h80 -> pairs (1,0),(0,0),(0,0),(0,0),(0,0),(0,0),(0,0),(0,1) contiguous, TxReadyHS high exactly 2 cycles, then trail value 0.
REQ-031 SHALL test TxValidHS=0 at first ready slot -> TRAIL directly after sync; trail value 0 (last sync bit 1).
REQ-032 SHALL test TxRequestHS falling at pair index 1 of byte 8'hFF -> byte completes as four (1,1) pairs, TxReadyHS stays 0, trail (0,0) for TRAIL_CYCLES.
REQ-033 SHALL test TxRequestHS held high through TRAIL -> one IDLE cycle with Enable=0, then new SYNC.
